// File: rtl/addsub_result_stage.sv
// addsub_result_stage
//   Registered result-capture stage for a WIDTH-bit ripple adder/subtractor.
//   Derives ALU status flags from the raw sum/cout and operand sign bits and
//   buffers them in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
//   It also keeps a saturating count of accepted signed-overflow results.
//
// Ports
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready    upstream handshake (in_ready depends on stored state only)
//   sum, cout            raw adder/subtractor outputs
//   mode                 0 = add, 1 = subtract
//   a_msb, b_msb         operand sign bits (b before mode inversion)
//   out_valid/out_ready  downstream handshake for the head entry
//   out_result, out_carry, out_borrow, out_zero, out_neg, out_ovf
//                        head entry; all zero while the FIFO is empty
//   occupancy            number of entries held
//   ovf_count, ovf_clr   saturating overflow event count and its synchronous clear
module addsub_result_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         sum,
  input  logic                     cout,
  input  logic                     mode,
  input  logic                     a_msb,
  input  logic                     b_msb,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_carry,
  output logic                     out_borrow,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_ovf,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         ovf_count,
  input  logic                     ovf_clr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             borrow;
    logic             zero;
    logic             neg;
    logic             ovf;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   ovf_cnt_q, ovf_cnt_d;

  entry_t in_entry;
  entry_t head;
  logic   b_eff;
  logic   push;
  logic   pop;

  // Flags for the result currently presented upstream.
  always_comb begin
    b_eff           = b_msb ^ mode;
    in_entry        = '0;
    in_entry.result = sum;
    in_entry.carry  = cout;
    in_entry.borrow = mode & ~cout;
    in_entry.zero   = (sum == '0);
    in_entry.neg    = sum[WIDTH-1];
    in_entry.ovf    = (a_msb == b_eff) & (sum[WIDTH-1] != a_msb);
  end

  assign in_ready  = (count_q < DEPTH_OCC);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr) begin
      ovf_cnt_d = '0;
    end else if (push && in_entry.ovf && (ovf_cnt_q != CNT_MAX)) begin
      ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_cnt_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // Popped slots keep stale data, so the head is masked while empty.
  assign head = out_valid ? mem_q[rd_ptr_q] : '0;

  assign out_result = head.result;
  assign out_carry  = head.carry;
  assign out_borrow = head.borrow;
  assign out_zero   = head.zero;
  assign out_neg    = head.neg;
  assign out_ovf    = head.ovf;
  assign occupancy  = count_q;
  assign ovf_count  = ovf_cnt_q;

endmodule

// File: tb/tb_addsub_result_stage.sv
module tb_addsub_result_stage;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, out_ready, ovf_clr;
  logic [3:0] sum;
  logic       cout, mode, a_msb, b_msb;

  logic       m_in_ready, m_out_valid, m_carry, m_borrow, m_zero, m_neg, m_ovf;
  logic [3:0] m_result;
  logic [1:0] m_occ;
  logic [7:0] m_cnt;

  logic       s_in_ready, s_out_valid, s_carry, s_borrow, s_zero, s_neg, s_ovf;
  logic [3:0] s_result;
  logic [1:0] s_occ;
  logic [1:0] s_cnt;

  always #5 clk = ~clk;

  addsub_result_stage #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(8)) u_main (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready),
    .sum(sum), .cout(cout), .mode(mode), .a_msb(a_msb), .b_msb(b_msb),
    .out_valid(m_out_valid), .out_ready(out_ready), .out_result(m_result),
    .out_carry(m_carry), .out_borrow(m_borrow), .out_zero(m_zero),
    .out_neg(m_neg), .out_ovf(m_ovf), .occupancy(m_occ),
    .ovf_count(m_cnt), .ovf_clr(ovf_clr)
  );

  addsub_result_stage #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .sum(sum), .cout(cout), .mode(mode), .a_msb(a_msb), .b_msb(b_msb),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_result(s_result),
    .out_carry(s_carry), .out_borrow(s_borrow), .out_zero(s_zero),
    .out_neg(s_neg), .out_ovf(s_ovf), .occupancy(s_occ),
    .ovf_count(s_cnt), .ovf_clr(ovf_clr)
  );

  typedef struct {
    logic [3:0] res;
    logic       c, b, z, n, v;
  } ent_t;

  ent_t q[$];
  ent_t cur;
  int   cnt_m, cnt_s;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  // Reference: perform the arithmetic on integers and read flags off the math.
  function automatic ent_t make(input logic [3:0] a, input logic [3:0] b, input logic m);
    ent_t e;
    int ua, ub, r, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    r  = m ? (ua - ub + 16) : (ua + ub);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    sr = m ? (sa - sb) : (sa + sb);
    e.res = 4'(r % 16);
    e.c   = (r >= 16);
    e.b   = m && (r < 16);
    e.z   = ((r % 16) == 0);
    e.n   = ((r % 16) >= 8);
    e.v   = (sr < -8) || (sr > 7);
    return e;
  endfunction

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic m, input logic v);
    cur      = make(a, b, m);
    sum      = cur.res;
    cout     = cur.c;
    mode     = m;
    a_msb    = a[3];
    b_msb    = b[3];
    in_valid = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    ent_t h;
    logic ev;
    ev = (q.size() != 0);
    if (ev) h = q[0];
    else begin
      h.res = '0; h.c = 0; h.b = 0; h.z = 0; h.n = 0; h.v = 0;
    end
    check({tag, " m_valid"},  32'(m_out_valid), 32'(ev));
    check({tag, " m_ready"},  32'(m_in_ready),  32'(q.size() < DEPTH));
    check({tag, " m_occ"},    32'(m_occ),       32'(q.size()));
    check({tag, " m_result"}, 32'(m_result),    32'(h.res));
    check({tag, " m_flags"},  32'({m_carry, m_borrow, m_zero, m_neg, m_ovf}),
                              32'({h.c, h.b, h.z, h.n, h.v}));
    check({tag, " m_cnt"},    32'(m_cnt),       32'(cnt_m));
    check({tag, " s_valid"},  32'(s_out_valid), 32'(ev));
    check({tag, " s_ready"},  32'(s_in_ready),  32'(q.size() < DEPTH));
    check({tag, " s_occ"},    32'(s_occ),       32'(q.size()));
    check({tag, " s_result"}, 32'(s_result),    32'(h.res));
    check({tag, " s_flags"},  32'({s_carry, s_borrow, s_zero, s_neg, s_ovf}),
                              32'({h.c, h.b, h.z, h.n, h.v}));
    check({tag, " s_cnt"},    32'(s_cnt),       32'(cnt_s));
  endtask

  // Advance one clock: update the model with the inputs seen at the edge, then check.
  task automatic tick(input string tag);
    bit do_push, do_pop;
    @(posedge clk);
    do_push = in_valid && (q.size() < DEPTH);
    do_pop  = out_ready && (q.size() != 0);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(cur);
    if (ovf_clr) begin
      cnt_m = 0;
      cnt_s = 0;
    end else if (do_push && cur.v) begin
      if (cnt_m < 255) cnt_m++;
      if (cnt_s < 3) cnt_s++;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b0; ovf_clr = 1'b0;
    drive(4'd0, 4'd0, 1'b0, 1'b0);
    cnt_m = 0; cnt_s = 0;
    #12;
    check_all("reset");
    rst = 1'b0;

    // Directed arithmetic cases
    out_ready = 1'b1;
    drive(4'd5, 4'd3, 1'b0, 1'b1); tick("add_ovf");
    drive(4'd3, 4'd5, 1'b1, 1'b1); tick("sub_borrow");
    drive(4'd7, 4'd7, 1'b1, 1'b1); tick("sub_zero");
    drive(4'd7, 4'd7, 1'b1, 1'b0); tick("drain");
    tick("empty_pop");

    // Backpressure: third result is dropped while full
    out_ready = 1'b0;
    drive(4'd1, 4'd0, 1'b0, 1'b1); tick("bp_push1");
    drive(4'd2, 4'd0, 1'b0, 1'b1); tick("bp_push2");
    drive(4'd3, 4'd0, 1'b0, 1'b1); tick("bp_full");
    tick("bp_hold");
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick("bp_pop1");
    tick("bp_pop2");

    // Full with a pop in the same cycle still ignores in_valid
    out_ready = 1'b0;
    drive(4'd4, 4'd1, 1'b0, 1'b1); tick("fp_push1");
    drive(4'd6, 4'd2, 1'b1, 1'b1); tick("fp_push2");
    out_ready = 1'b1;
    drive(4'd9, 4'd9, 1'b0, 1'b1); tick("fp_full_pop");
    in_valid = 1'b0; tick("fp_drain1");
    tick("fp_drain2");

    // Counter saturation and clear priority
    for (int i = 0; i < 5; i++) begin
      drive(4'd5, 4'd3, 1'b0, 1'b1); tick("sat_push");
    end
    ovf_clr = 1'b1;
    drive(4'd6, 4'd4, 1'b0, 1'b1); tick("clr_vs_inc");
    ovf_clr = 1'b0;
    in_valid = 1'b0; tick("clr_after");
    tick("clr_drain");

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)),
            1'($urandom_range(3) != 0));
      out_ready = 1'($urandom_range(2) != 0);
      ovf_clr   = ($urandom_range(31) == 0);
      tick("rand");
    end
    ovf_clr = 1'b0;

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    drive(4'd5, 4'd3, 1'b0, 1'b1); tick("ar_push1");
    drive(4'd12, 4'd2, 1'b1, 1'b1); tick("ar_push2");
    tick("ar_full");
    in_valid = 1'b0;
    #2 rst = 1'b1;
    q.delete();
    cnt_m = 0; cnt_s = 0;
    #1 check_all("async_rst");
    #1 rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      drive(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)),
            1'($urandom_range(1)));
      out_ready = 1'($urandom_range(1));
      tick("post_rst");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/addsub_result_stage.md
Name: addsub_result_stage

Overview:
- Registered result-capture stage that sits directly downstream of the 4-bit ripple adder/subtractor.
- Takes the raw sum/cout plus the operand sign bits and mode, and derives ALU status flags (carry, borrow, zero, negative, signed overflow).
- Buffers results in a small FIFO with valid/ready handshakes, so a stalled consumer never loses an add/sub result.
- Also keeps a saturating count of signed-overflow events for debug/status reads.

Parameters:
- WIDTH, 4: data width of sum/result; must match the adder/subtractor width.
- DEPTH, 2: number of result entries buffered; power of two, >=2.
- CNT_W, 8: width of the overflow event counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream presents a valid add/sub result this cycle
- in_ready  out  1  stage can accept an entry this cycle
- sum  in  WIDTH  sum bus from the adder/subtractor
- cout  in  1  carry-out from the adder/subtractor
- mode  in  1  operation of this result: 0 = add, 1 = subtract
- a_msb  in  1  operand A[WIDTH-1]
- b_msb  in  1  operand B[WIDTH-1], before mode inversion
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head entry
- out_result  out  WIDTH  head entry result
- out_carry  out  1  head carry flag
- out_borrow  out  1  head borrow flag
- out_zero  out  1  head zero flag
- out_neg  out  1  head negative flag
- out_ovf  out  1  head signed-overflow flag
- occupancy  out  clog2(DEPTH)+1  entries currently held
- ovf_count  out  CNT_W  saturating count of accepted entries with ovf=1
- ovf_clr  in  1  synchronous clear of ovf_count

Behaviour:
- Reset (async, rst=1): FIFO emptied; occupancy=0, out_valid=0; all out_* data/flags=0; ovf_count=0. in_ready=1 once rst deasserts.
- Flag computation, combinational on the input side and captured at push:
  - carry = cout
  - borrow = mode & ~cout
  - zero = (sum == 0)
  - neg = sum[WIDTH-1]
  - b_eff = b_msb ^ mode
  - ovf = (a_msb == b_eff) & (sum[WIDTH-1] != a_msb)
- Push when in_valid & in_ready. Pop when out_valid & out_ready.
- in_ready = (occupancy < DEPTH); registered-state only, with no combinational path from out_ready.
- out_valid = (occupancy != 0). out_* fields show the head entry; all are 0 when empty.
- Latency: an entry pushed in cycle N is visible on out_* in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop (0 < occupancy < DEPTH): both happen, occupancy unchanged, order preserved.
- Full: in_ready=0 and any in_valid is ignored, even if a pop happens that same cycle.
- Empty with out_ready=1: no pop, nothing changes.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- Data stability: out_* must stay stable while out_valid=1 & out_ready=0.
- ovf_count:
  - Increments by 1 on each push whose ovf=1; saturates at 2^CNT_W-1.
  - ovf_clr has priority over an increment in the same cycle; result is 0.
- Mid-operation reset: all stored entries are discarded immediately and outputs return to reset values asynchronously.
- in_valid is sampled only with in_ready; upstream data may change freely while not accepted.

Test Plan:
- Add overflow: sum=4'h8, cout=0, mode=0, a_msb=0, b_msb=0 (5+3), out_ready=1 -> next cycle out_result=8, neg=1, ovf=1, carry=0, borrow=0; ovf_count=1.
- Subtract with borrow: sum=4'hE, cout=0, mode=1, a_msb=0, b_msb=0 (3-5) -> out_result=14, borrow=1, neg=1, ovf=0, zero=0.
- Subtract to zero: sum=0, cout=1, mode=1, a_msb=0, b_msb=0 (7-7) -> zero=1, carry=1, borrow=0, ovf=0.
- Backpressure: out_ready=0, push 3 results 1,2,3 back-to-back -> occupancy=2, in_ready=0, third result dropped. Then out_ready=1 -> outputs 1 then 2 in consecutive cycles, in_ready=1 after the first pop, occupancy returns to 0.
- Saturation and clear: CNT_W=2, push 5 overflow entries -> ovf_count sticks at 3. ovf_clr together with an overflow push -> ovf_count=0.
- Async reset with 2 entries held and out_ready=0: assert rst mid-cycle -> out_valid=0, occupancy=0, out_*=0, ovf_count=0 before the next clock edge.
